// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM state
// encoding and the handler-vector address helper.
package exc_pkg;

   localparam logic [3:0] CAUSE_NONE     = 4'h0;
   localparam logic [3:0] CAUSE_ADDR     = 4'h1;
   localparam logic [3:0] CAUSE_ILL      = 4'h2;
   localparam logic [3:0] CAUSE_PRIV     = 4'h3;
   localparam logic [3:0] CAUSE_OVF      = 4'h4;
   localparam logic [3:0] CAUSE_SYS      = 4'h5;
   localparam logic [3:0] CAUSE_IRQ_BASE = 4'h8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   // Qualified synchronous fault requests, listed from highest to lowest priority.
   typedef struct packed {
      logic addr_err;
      logic ill_inst;
      logic priv;
      logic ovf;
      logic syscall;
   } sync_req_t;

   // Each handler gets a 16-byte slot above the base; the sum wraps modulo 2^32.
   function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                               input logic [3:0]  cause);
      return base + {24'h0, cause, 4'h0};
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the winning request and its cause code.
// Synchronous faults always beat interrupts; among interrupts bit 0 wins.
module exc_prio_enc
   import exc_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  sync_req_t            sync_i,
   input  logic [NUM_IRQ-1:0]   irq_i,
   output logic                 valid_o,
   output logic [3:0]           cause_o
);

   // Lowest-priority sources are written first so higher ones overwrite them.
   always_comb begin
      valid_o = 1'b0;
      cause_o = CAUSE_NONE;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_i[i]) begin
            valid_o = 1'b1;
            cause_o = CAUSE_IRQ_BASE + 4'(i);
         end
      end
      if (sync_i.syscall) begin
         valid_o = 1'b1;
         cause_o = CAUSE_SYS;
      end
      if (sync_i.ovf) begin
         valid_o = 1'b1;
         cause_o = CAUSE_OVF;
      end
      if (sync_i.priv) begin
         valid_o = 1'b1;
         cause_o = CAUSE_PRIV;
      end
      if (sync_i.ill_inst) begin
         valid_o = 1'b1;
         cause_o = CAUSE_ILL;
      end
      if (sync_i.addr_err) begin
         valid_o = 1'b1;
         cause_o = CAUSE_ADDR;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller feeding the status register: qualifies and
// prioritises faults and interrupts, issues exception/rfe strobes, EPC/cause and flush.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int          NUM_IRQ      = 4,
   parameter int          FLUSH_CYCLES = 3,
   parameter logic [31:0] VEC_BASE     = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inst_valid,
   input  logic [31:0]        pc_in,
   input  logic               addr_err,
   input  logic               ill_inst,
   input  logic               priv_inst,
   input  logic               ovf,
   input  logic               syscall,
   input  logic               rfe_req,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               IE_c,
   input  logic               s_u_c,
   output logic               exception,
   output logic               rfe,
   output logic               flush,
   output logic [31:0]        vec_pc,
   output logic [31:0]        epc,
   output logic [3:0]         cause,
   output logic               irq_pending
);

   localparam int             CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               exception_q, exception_d;
   logic               rfe_q, rfe_d;
   logic               flush_q, flush_d;
   logic [31:0]        vec_q, vec_d;
   logic [31:0]        epc_q, epc_d;
   logic [3:0]         cause_q, cause_d;

   sync_req_t          sync_req;
   logic [NUM_IRQ-1:0] irq_req;
   logic               win_valid;
   logic [3:0]         win_cause;
   logic               take;
   logic               do_rfe;

   assign sync_req = '{addr_err: inst_valid & addr_err,
                       ill_inst: inst_valid & ill_inst,
                       priv:     inst_valid & priv_inst & ~s_u_c,
                       ovf:      inst_valid & ovf,
                       syscall:  inst_valid & syscall};
   assign irq_req  = irq & {NUM_IRQ{IE_c}};

   exc_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio (
      .sync_i  (sync_req),
      .irq_i   (irq_req),
      .valid_o (win_valid),
      .cause_o (win_cause)
   );

   // Requests are only honoured in IDLE; an exception always pre-empts rfe.
   assign take   = (state_q == IDLE) & win_valid;
   assign do_rfe = (state_q == IDLE) & ~win_valid & inst_valid & rfe_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         exception_q <= 1'b0;
         rfe_q       <= 1'b0;
         flush_q     <= 1'b0;
         vec_q       <= '0;
         epc_q       <= '0;
         cause_q     <= CAUSE_NONE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exception_q <= exception_d;
         rfe_q       <= rfe_d;
         flush_q     <= flush_d;
         vec_q       <= vec_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
      end
   end

   // cnt_q counts the flush cycles still owed after the current one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = FLUSH;
               cnt_d   = CNT_LOAD;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      exception_d = take;
      rfe_d       = do_rfe;
      flush_d     = take | do_rfe | ((state_q == FLUSH) && (cnt_q != '0));
      epc_d       = take ? pc_in : epc_q;
      cause_d     = take ? win_cause : cause_q;
      vec_d       = take ? vector_addr(VEC_BASE, win_cause) : vec_q;
   end

   assign exception   = exception_q;
   assign rfe         = rfe_q;
   assign flush       = flush_q;
   assign vec_pc      = vec_q;
   assign epc         = epc_q;
   assign cause       = cause_q;
   assign irq_pending = |irq;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: table of single-request vectors plus
// hand-written multi-cycle sequences, with expected strobes queued per request.
module tb_exc_ctrl;

   localparam int          NUM_IRQ      = 4;
   localparam int          FLUSH_CYCLES = 3;
   localparam logic [31:0] VEC_BASE     = 32'h0000_0080;

   logic               clk;
   logic               rst;
   logic               inst_valid;
   logic [31:0]        pc_in;
   logic               addr_err, ill_inst, priv_inst, ovf, syscall, rfe_req;
   logic [NUM_IRQ-1:0] irq;
   logic               IE_c, s_u_c;
   logic               exception, rfe, flush, irq_pending;
   logic [31:0]        vec_pc, epc;
   logic [3:0]         cause;

   exc_ctrl #(
      .NUM_IRQ      (NUM_IRQ),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .VEC_BASE     (VEC_BASE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_valid  (inst_valid),
      .pc_in       (pc_in),
      .addr_err    (addr_err),
      .ill_inst    (ill_inst),
      .priv_inst   (priv_inst),
      .ovf         (ovf),
      .syscall     (syscall),
      .rfe_req     (rfe_req),
      .irq         (irq),
      .IE_c        (IE_c),
      .s_u_c       (s_u_c),
      .exception   (exception),
      .rfe         (rfe),
      .flush       (flush),
      .vec_pc      (vec_pc),
      .epc         (epc),
      .cause       (cause),
      .irq_pending (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic        ae, il, pv, ov, sc, rf;
      logic [3:0]  irq;
      logic        ie, su;
      logic        ex, rx;
      logic [3:0]  cs;
   } vec_t;

   typedef struct {
      logic        exc;
      logic        rfe;
      logic        fl;
      logic [3:0]  cause;
      logic [31:0] epc;
      logic [31:0] vec;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[13];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_epc   = 32'h0;
   logic [31:0] m_vec   = 32'h0;
   logic [3:0]  m_cause = 4'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Record what the next edge must produce; the model keeps epc/cause/vec history.
   task automatic push_exp(input logic exc, input logic rf, input logic [3:0] cs,
                           input logic [31:0] pc);
      exp_t e;
      if (exc) begin
         m_epc   = pc;
         m_cause = cs;
         m_vec   = VEC_BASE + ({28'h0, cs} << 4);
      end
      e.exc   = exc;
      e.rfe   = rf;
      e.fl    = exc | rf;
      e.cause = m_cause;
      e.epc   = m_epc;
      e.vec   = m_vec;
      sb.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_exception"}, 32'(exception), 32'(e.exc));
      chk({tag, "_rfe"},       32'(rfe),       32'(e.rfe));
      chk({tag, "_flush"},     32'(flush),     32'(e.fl));
      chk({tag, "_cause"},     32'(cause),     32'(e.cause));
      chk({tag, "_epc"},       epc,            e.epc);
      chk({tag, "_vec_pc"},    vec_pc,         e.vec);
   endtask

   task automatic clr_sync();
      inst_valid = 1'b0;
      addr_err   = 1'b0;
      ill_inst   = 1'b0;
      priv_inst  = 1'b0;
      ovf        = 1'b0;
      syscall    = 1'b0;
      rfe_req    = 1'b0;
   endtask

   task automatic settle(input string tag);
      repeat (FLUSH_CYCLES) @(negedge clk);
      chk({tag, "_settle_flush"}, 32'(flush), 32'h0);
      chk({tag, "_settle_exc"},   32'(exception), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA};
      tbl[1]  = '{1'b1, 32'h0000_1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
      tbl[2]  = '{1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3};
      tbl[3]  = '{1'b1, 32'h0000_2100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0};
      tbl[4]  = '{1'b1, 32'h0000_2200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5};
      tbl[5]  = '{1'b1, 32'h0000_2300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2};
      tbl[6]  = '{1'b1, 32'h0000_2400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'h4};
      tbl[7]  = '{1'b0, 32'h0000_2500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
      tbl[8]  = '{1'b0, 32'h0000_2600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB};
      tbl[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5};
      tbl[10] = '{1'b0, 32'h0000_2700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9};
      tbl[11] = '{1'b0, 32'h0000_2800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
      tbl[12] = '{1'b0, 32'h0000_2900, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};

      // Reset held with interrupts pending and enabled.
      clr_sync();
      rst   = 1'b1;
      irq   = 4'hF;
      IE_c  = 1'b1;
      s_u_c = 1'b1;
      pc_in = 32'h0000_0500;
      repeat (2) @(negedge clk);
      chk("rst_exception", 32'(exception), 32'h0);
      chk("rst_flush",     32'(flush),     32'h0);
      chk("rst_rfe",       32'(rfe),       32'h0);
      chk("rst_epc",       epc,            32'h0);
      chk("rst_cause",     32'(cause),     32'h0);
      chk("rst_vec_pc",    vec_pc,         32'h0);
      chk("rst_irq_pending", 32'(irq_pending), 32'h1);
      rst = 1'b0;
      chk("rst_release_exc", 32'(exception), 32'h0);
      push_exp(1'b1, 1'b0, 4'h8, pc_in);
      @(negedge clk);
      irq = 4'h0;
      sb_check("rst_take");
      settle("rst");

      // Table of single-cycle requests applied from IDLE.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         inst_valid = tbl[i].iv;
         pc_in      = tbl[i].pc;
         addr_err   = tbl[i].ae;
         ill_inst   = tbl[i].il;
         priv_inst  = tbl[i].pv;
         ovf        = tbl[i].ov;
         syscall    = tbl[i].sc;
         rfe_req    = tbl[i].rf;
         irq        = tbl[i].irq;
         IE_c       = tbl[i].ie;
         s_u_c      = tbl[i].su;
         push_exp(tbl[i].ex, tbl[i].rx, tbl[i].cs, tbl[i].pc);
         @(negedge clk);
         clr_sync();
         irq   = 4'h0;
         IE_c  = 1'b1;
         s_u_c = 1'b1;
         sb_check($sformatf("vec%0d", i));
         settle($sformatf("vec%0d", i));
      end

      // Interrupt take: flush spans exactly FLUSH_CYCLES cycles.
      irq   = 4'b0100;
      pc_in = 32'h0000_1000;
      push_exp(1'b1, 1'b0, 4'hA, pc_in);
      @(negedge clk);
      irq = 4'h0;
      sb_check("irq_take");
      chk("irq_vec_abs", vec_pc, 32'h0000_0120);
      @(negedge clk);
      chk("irq_n2_exc",   32'(exception), 32'h0);
      chk("irq_n2_flush", 32'(flush),     32'h1);
      @(negedge clk);
      chk("irq_n3_exc",   32'(exception), 32'h0);
      chk("irq_n3_flush", 32'(flush),     32'h1);
      @(negedge clk);
      chk("irq_n4_flush", 32'(flush),     32'h0);
      chk("irq_vec_hold", vec_pc,         32'h0000_0120);

      // Masked interrupt stays pending until IE_c rises.
      IE_c  = 1'b0;
      irq   = 4'b0001;
      pc_in = 32'h0000_1800;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("mask_exc_%0d", i), 32'(exception), 32'h0);
      end
      chk("mask_irq_pending", 32'(irq_pending), 32'h1);
      IE_c = 1'b1;
      push_exp(1'b1, 1'b0, 4'h8, pc_in);
      @(negedge clk);
      irq = 4'h0;
      sb_check("mask_take");
      settle("mask");

      // Sync fault beats irq; irq is retaken once the flush finishes.
      inst_valid = 1'b1;
      addr_err   = 1'b1;
      ovf        = 1'b1;
      irq        = 4'b0001;
      pc_in      = 32'h0000_3000;
      push_exp(1'b1, 1'b0, 4'h1, pc_in);
      @(negedge clk);
      clr_sync();
      pc_in = 32'h0000_3100;
      sb_check("prio_sync");
      chk("prio_vec_abs", vec_pc, 32'h0000_0090);
      @(negedge clk);
      chk("prio_f2_exc",   32'(exception), 32'h0);
      chk("prio_f2_flush", 32'(flush),     32'h1);
      @(negedge clk);
      chk("prio_f3_flush", 32'(flush),     32'h1);
      @(negedge clk);
      chk("prio_idle_exc",   32'(exception), 32'h0);
      chk("prio_idle_flush", 32'(flush),     32'h0);
      push_exp(1'b1, 1'b0, 4'h8, pc_in);
      @(negedge clk);
      irq = 4'h0;
      sb_check("prio_irq");
      settle("prio");

      // rfe alone: one-cycle strobe and flush, epc untouched.
      inst_valid = 1'b1;
      rfe_req    = 1'b1;
      pc_in      = 32'h0000_5000;
      push_exp(1'b0, 1'b1, 4'h0, pc_in);
      @(negedge clk);
      clr_sync();
      sb_check("rfe_alone");
      @(negedge clk);
      chk("rfe_alone_off",   32'(rfe),   32'h0);
      chk("rfe_alone_flush", 32'(flush), 32'h0);

      // rfe_req arriving during FLUSH is ignored.
      inst_valid = 1'b1;
      syscall    = 1'b1;
      pc_in      = 32'h0000_4000;
      push_exp(1'b1, 1'b0, 4'h5, pc_in);
      @(negedge clk);
      syscall = 1'b0;
      rfe_req = 1'b1;
      sb_check("rfe_fl_take");
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         @(negedge clk);
         chk($sformatf("rfe_fl_ignored_%0d", i), 32'(rfe), 32'h0);
      end
      clr_sync();
      chk("rfe_fl_epc", epc, 32'h0000_4000);
      settle("rfe_fl");

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt controller that sits directly upstream of the status register block. It collects synchronous faults from the execute stage and level interrupts, masks interrupts with IE_c, and prioritises requests. It then drives the single-cycle exception and rfe strobes into the status register, while latching EPC/cause and generating the pipeline flush and handler vector.

Parameters:
NUM_IRQ, 4, number of level-sensitive interrupt lines (1..8)
FLUSH_CYCLES, 3, cycles flush stays high after an exception is taken (>=1)
VEC_BASE, 32'h0000_0080, handler vector base address

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
inst_valid  in  1  execute stage holds a valid instruction this cycle
pc_in  in  32  PC of the execute-stage instruction
addr_err  in  1  misaligned access (qualified by inst_valid)
ill_inst  in  1  illegal opcode (qualified by inst_valid)
priv_inst  in  1  privileged opcode; faults when s_u_c=0 (qualified by inst_valid)
ovf  in  1  arithmetic overflow (qualified by inst_valid)
syscall  in  1  syscall instruction (qualified by inst_valid)
rfe_req  in  1  decoded rfe instruction (qualified by inst_valid)
irq  in  NUM_IRQ  level interrupt requests, bit 0 highest priority
IE_c  in  1  interrupt enable from status register
s_u_c  in  1  1=supervisor, 0=user, from status register
exception  out  1  one-cycle strobe to status register
rfe  out  1  one-cycle strobe to status register
flush  out  1  kill fetch/decode/execute contents
vec_pc  out  32  handler address, valid while exception=1
epc  out  32  PC of the excepting/interrupted instruction
cause  out  4  cause code of last exception taken
irq_pending  out  1  any irq line high, regardless of IE_c

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; exception, rfe, flush, vec_pc, epc, cause = 0; flush counter = 0. Reset mid-FLUSH aborts the flush the same edge.
- irq_pending = |irq. It is combinational and not affected by reset or state.
- Request evaluation happens only in IDLE. Sync sources count only when inst_valid=1. priv_inst counts only when s_u_c=0. irq counts only when IE_c=1.
- Fixed priority, high to low: addr_err (1), ill_inst (2), priv (3), ovf (4), syscall (5), irq[i] (8+i).
- Take: when a winning request exists in cycle N (IDLE), the following all happen at edge N+1:
  - exception=1 for exactly one cycle;
  - cause=code; epc=pc_in sampled at N;
  - vec_pc = VEC_BASE + (cause<<4);
  - flush=1; state goes to FLUSH.
- FLUSH: flush stays high for FLUSH_CYCLES cycles including the exception cycle, then returns to IDLE. All requests and rfe_req are ignored during FLUSH. irq lines are level, so they remain pending and are re-evaluated in IDLE against the updated IE_c.
- rfe: rfe_req & inst_valid in IDLE with no winning request gives rfe=1 for one cycle at N+1, flush=1 for one cycle, and state stays IDLE. epc and cause are unchanged.
- Simultaneous rfe_req and any winning request: the exception wins and rfe is dropped, matching the status register's precedence.
- Simultaneous irq and sync fault: the sync fault wins. The irq remains pending.
- exception and rfe are never high in the same cycle. Both strobes are registered, so there is no combinational path from inputs to strobes.
- vec_pc holds its value after the strobe until the next take. epc and cause hold until the next take or reset.
- Arithmetic is 32-bit unsigned; vec_pc wraps modulo 2^32.

Decomposition:
- Package exc_pkg:
  - cause code constants CAUSE_ADDR=4'h1, CAUSE_ILL=4'h2, CAUSE_PRIV=4'h3, CAUSE_OVF=4'h4, CAUSE_SYS=4'h5, CAUSE_IRQ_BASE=4'h8;
  - state encoding IDLE/FLUSH.
- One sub-module, exc_prio_enc: purely combinational priority encoder from masked request vector to {valid, cause}.

Test Plan:
- Reset: hold rst=1 two cycles with irq=4'hF, IE_c=1 -> exception=0, flush=0, epc=0, cause=0, and 0 for the first cycle after release. Exception then follows at the next edge.
- Interrupt: IE_c=1, irq=4'b0100, pc_in=32'h0000_1000 at cycle N -> exception=1 at N+1 only, cause=4'hA, epc=32'h1000, vec_pc=32'h0000_0120, flush high N+1..N+3.
- Masking: IE_c=0, irq=4'b0001 for 10 cycles -> no exception, irq_pending=1. Raising IE_c gives the take on the next edge with cause=4'h8.
- Priority: inst_valid=1, addr_err=ovf=1, irq[0]=1, IE_c=1 -> cause=4'h1, vec_pc=32'h90. After FLUSH, with irq still high, a second take with cause=4'h8.
- Privilege: priv_inst=1 with s_u_c=1 -> nothing. With s_u_c=0 and pc_in=32'h2004 -> cause=4'h3, epc=32'h2004.
- rfe: rfe_req=1 alone -> rfe=1 for one cycle, flush one cycle, epc unchanged. rfe_req together with syscall -> exception=1, cause=4'h5, rfe stays 0. rfe_req during FLUSH -> ignored.
